// File: rtl/mp_adder_seq.sv
// mp_adder_seq: byte-serial multi-precision add/subtract sequencer.
//
// Adds or subtracts two W = 8*NBYTES bit operands one byte per clock,
// LSB first, through a single 8-bit adder slice. The carry between bytes
// lives in a carry flop. In subtract mode B is inverted and the borrow-in
// becomes an inverted carry-in, so A - B - borrow = A + ~B + ~borrow.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   sub    in   0 = A+B+cin, 1 = A-B-cin (cin acts as borrow-in)
//   a, b   in   W-bit operands, latched on an accepted start
//   cin    in   carry-in / borrow-in, latched on an accepted start
//   busy   out  high from the accept edge until the done edge
//   done   out  one-cycle pulse, result valid
//   sum    out  W-bit result register
//   cout   out  final carry of the top byte (sub: 1 = no borrow)
//   ovf    out  signed two's-complement overflow of the full result
module mp_adder_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic            carry_r;
    logic            sub_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            busy_r;
    logic            done_r;
    logic            cout_r;
    logic            ovf_r;

    logic [7:0]      a_byte_s;
    logic [7:0]      b_byte_s;
    logic [7:0]      b_eff_s;
    logic [7:0]      s_s;
    logic            c_s;

    // Shared 8-bit adder slice operating on the currently indexed byte.
    always_comb begin
        a_byte_s = a_r[{idx_r, 3'b000} +: 8];
        b_byte_s = b_r[{idx_r, 3'b000} +: 8];
        if (sub_r) begin
            b_eff_s = ~b_byte_s;
        end else begin
            b_eff_s = b_byte_s;
        end
        {c_s, s_s} = {1'b0, a_byte_s} + {1'b0, b_eff_s} + {8'd0, carry_r};
    end

    // Sequencer FSM with all result/handshake outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            carry_r <= 1'b0;
            sub_r   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        sub_r   <= sub;
                        // Subtract carries ~borrow into the first byte.
                        carry_r <= sub ? ~cin : cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    sum_r[{idx_r, 3'b000} +: 8] <= s_s;
                    carry_r <= c_s;
                    if (idx_r == LAST_IDX) begin
                        cout_r  <= c_s;
                        // Top-byte operands carry the full-width sign bits.
                        ovf_r   <= (a_byte_s[7] == b_eff_s[7]) && (s_s[7] != a_byte_s[7]);
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    idx_r   <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    idx_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_mp_adder_seq.sv
// Self-checking bench for mp_adder_seq (NBYTES = 4): directed test-plan
// vectors, random vectors, a held-start handshake run and an asynchronous
// reset in the middle of an operation, checked against a wide-integer model.
module tb_mp_adder_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;
    localparam longint MAXS = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam longint MINS = -(64'sd1 <<< (W - 1));

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int vectors;
    int miscompares;

    mp_adder_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on whole operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mc, input logic ms,
                         output logic [W-1:0] rs, output logic rc, output logic ro);
        longint sr;
        longint ua;
        longint ub;
        ua = longint'(ma);
        ub = longint'(mb);
        if (!ms) begin
            rs = ma + mb + W'(mc);
            rc = (ua + ub + longint'(mc)) > longint'({W{1'b1}});
            sr = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
        end else begin
            rs = ma - mb - W'(mc);
            rc = (ua >= ub + longint'(mc));
            sr = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mc);
        end
        ro = (sr > MAXS) || (sr < MINS);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, input string tag);
        logic [W-1:0] es;
        logic ec;
        logic eo;
        model(ta, tb_v, tc, ts, es, ec, eo);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs during RUN: the latched copies must be used.
        start = 1'b0; a = $urandom; b = $urandom; cin = ~tc; sub = ~ts;
        chk({tag, "_busy0"}, 64'(busy), 64'd1);
        chk({tag, "_sumclr"}, 64'(sum), 64'd0);
        for (int i = 1; i < NB; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_nodone"}, 64'(done), 64'd0);
        end
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busyoff"}, 64'(busy), 64'd0);
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, 64'(sum), 64'(es));
    endtask

    initial begin
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic         qc[$];
        logic         qs[$];
        logic [W-1:0] es;
        logic ec;
        logic eo;
        int dones;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        dones = 0;

        // Reset state.
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed test-plan vectors.
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, "bytecarry");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, "fullwrap");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "posovf");
        run_op(32'h00000001, 32'h00000001, 1'b1, 1'b0, "cin1");
        run_op(32'h80000001, 32'h80000000, 1'b1, 1'b0, "cinovf");
        run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, "subborrow");
        run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, "subovf");
        run_op(32'h00000000, 32'h00000000, 1'b1, 1'b1, "subbin");

        // Random vectors.
        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        // Held start: one accept every NB+2 cycles, operands taken at accept.
        for (int c = 0; c < 3 * (NB + 2); c++) begin
            @(negedge clk);
            start = 1'b1;
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            if (c % (NB + 2) == 0) begin
                qa.push_back(a); qb.push_back(b); qc.push_back(cin); qs.push_back(sub);
            end
            @(posedge clk);
            #1;
            chk("hs_done", 64'(done), 64'(c % (NB + 2) == NB));
            if (done === 1'b1 && qa.size() > 0) begin
                dones++;
                model(qa.pop_front(), qb.pop_front(), qc.pop_front(), qs.pop_front(), es, ec, eo);
                chk("hs_sum", 64'(sum), 64'(es));
                chk("hs_cout", 64'(cout), 64'(ec));
                chk("hs_ovf", 64'(ovf), 64'(eo));
            end
        end
        chk("hs_count", 64'(dones), 64'd3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset while RUN is at idx=2.
        a = 32'hFEDCBA98; b = 32'h13579BDF; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_sum", 64'(sum), 64'd0);
        chk("mid_cout", 64'(cout), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NB + 2; i++) begin
            @(negedge clk);
            chk("mid_nodone", 64'(done), 64'd0);
        end
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, "postrst");
        chk("postrst_val", 64'(sum), 64'h23456789);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mp_adder_seq.md
Name: mp_adder_seq

Overview:
- Byte-serial multi-precision add/subtract sequencer built around one shared 8-bit adder slice (8-bit a, 8-bit b, carry-in; 8-bit sum, carry-out).
- Adds or subtracts two NBYTES-wide operands one byte per clock, LSB first, chaining the carry through a registered carry flop.
- Wide arithmetic then costs one 8-bit adder instead of a full-width adder.
- Sits between a requesting controller (start/done handshake) and the 8-bit adder datapath.

Parameters:
NBYTES, 4, operand width in bytes (>=2); total width W = 8*NBYTES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = A+B+cin; 1 = A-B-borrow, with cin as borrow-in
a  input  W  operand A; latched on accepted start
b  input  W  operand B; latched on accepted start
cin  input  1  carry-in (add) or borrow-in (sub); latched on accepted start
busy  output  1  high from the start-accept edge until the done edge
done  output  1  single-cycle pulse; result valid
sum  output  W  result register
cout  output  1  final carry-out of the top byte; in sub mode 1 means no borrow
ovf  output  1  signed two's-complement overflow of the full-width result

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
- Internal byte index, carry flop and operand registers are cleared.

FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> latch a, b, cin, sub; idx=0.
  - Carry flop = sub ? ~cin : cin.
  - busy=1 after edge k; state=RUN.
  - sum is cleared to 0 at accept.
- RUN: each edge computes byte idx:
  - {c, s} = A[idx] + (sub ? ~B[idx] : B[idx]) + carry.
  - sum[8*idx +: 8] <= s; carry <= c; idx++.
  - At idx = NBYTES-1 (edge k+NBYTES):
    - cout <= c.
    - ovf <= (top bit of A) == (top bit of effective B) and sum MSB != A MSB.
    - state=DONE, done=1, busy=0.
- DONE: lasts exactly one cycle; done=1. Next edge -> IDLE, done=0.
- Latency: done is high in the cycle following edge k+NBYTES, i.e. NBYTES cycles after start is accepted.
- sum, cout and ovf hold their values until the next accepted start.
- start while RUN or DONE: ignored, no queuing. The requester must re-assert start in IDLE.
- Input changes on a, b, cin, sub after accept: no effect; all computation uses the latched copies.
- Byte index: counts 0..NBYTES-1 with no wrap. Index width is clog2(NBYTES) and never exceeds NBYTES-1.
- Reset mid-RUN: immediate abort to the reset values above. No done pulse is produced.
- Back-to-back requests: minimum spacing between accepted starts is NBYTES+2 cycles.
- Arithmetic: all additions are unsigned 9-bit per byte; no saturation. Subtraction is A + ~B + ~borrow_in.

Test Plan (NBYTES=4):
- Byte-boundary carry: add, a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, ovf=0; done exactly 4 cycles after accept; busy high for 4 cycles.
- Full wrap: add, a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0. Then a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1.
- Carry-in path: add, a=0x00000001, b=0x00000001, cin=1 -> sum=0x00000003, cout=0. Then a=0x80000001, b=0x80000000, cin=1 -> sum=0x00000002, cout=1, ovf=1.
- Subtract with borrow: sub=1, a=0x00000005, b=0x00000007, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Handshake robustness: hold start=1 continuously with changing a/b -> exactly one done per NBYTES+2 cycles. Results match the operands latched at each accept. Operand changes during RUN are ignored.
- Reset mid-operation: drop rst_n asynchronously at RUN idx=2 -> busy, done, sum and cout go to 0 immediately, with no done pulse. After release, a new start completes correctly (0x12345678 + 0x11111111 = 0x23456789).
